// File: rtl/z_core_mem_pkg.sv
// Shared constants, FSM state type and access-legality helper for the Z-Core memory bridge.
package z_core_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Unsigned widths exist only for loads; alignment follows the access size.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = (a[0] == 1'b0);
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && (a[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/z_core_lane_align.sv
// Combinational byte-lane logic: store strobes/replicated data and load extraction/extension.
// Zero latency, no flow control.
module z_core_lane_align
  import z_core_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    if (we) begin
      case (funct3)
        F3_B: begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          wstrb = 4'b0011 << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
        F3_W:    wstrb = 4'b1111;
        default: wstrb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    shifted = load_word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/z_core_mem_bridge.sv
// Core memory port to valid/ready bus bridge; done 3 cycles after accept on a zero-wait bus, 1 on error.
// Request held stable until bus_req_ready; optional wait limit under Z_CORE_MEM_TIMEOUT_EN.
module z_core_mem_bridge
  import z_core_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [2:0]        core_funct3,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [31:0]       core_rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       load_data;
  logic              timeout_hit;

  z_core_lane_align u_lane (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .we         (we_q),
    .store_data (wdata_q),
    .load_word  (bus_rdata),
    .wstrb      (bus_wstrb),
    .wdata      (bus_wdata),
    .load_data  (load_data)
  );

  assign core_busy = (state != ST_IDLE);
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_we    = we_q;

`ifdef Z_CORE_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero in IDLE, so it starts from zero on every entry to REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if (state == ST_REQ || state == ST_RSP) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      f3_q          <= 3'b000;
      core_done     <= 1'b0;
      core_err      <= 1'b0;
      core_rdata    <= '0;
      bus_req_valid <= 1'b0;
    end else begin
      core_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core_req) begin
            we_q    <= core_we;
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
            f3_q    <= core_funct3;
            if (access_ok(core_we, core_funct3, core_addr[1:0])) begin
              state         <= ST_REQ;
              bus_req_valid <= 1'b1;
              core_err      <= 1'b0;
            end else begin
              state     <= ST_DONE;
              core_done <= 1'b1;
              core_err  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // A handshake in the final wait cycle still wins over the timeout.
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= ST_RSP;
          end else if (timeout_hit) begin
            bus_req_valid <= 1'b0;
            state         <= ST_DONE;
            core_done     <= 1'b1;
            core_err      <= 1'b1;
          end
        end
        ST_RSP: begin
          if (bus_rsp_valid) begin
            if (!we_q) core_rdata <= load_data;
            state     <= ST_DONE;
            core_done <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ST_DONE;
            core_done <= 1'b1;
            core_err  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/z_core_mem_bridge.md
Name: z_core_mem_bridge

Overview:
- Sits directly downstream of the Z-Core multi-cycle control unit, between its single memory port and the system memory bus.
- Turns one core access (address, write enable, write data, funct3) into a valid/ready bus request with byte strobes, then waits for the bus response.
- Returns aligned, sign/zero-extended load data and a one-cycle completion pulse that the core FSM uses to leave its MEM state.
- Detects misaligned and illegal-width accesses without issuing any bus traffic.

Parameters:
- ADDR_W, 32, width of the core and bus address.
- TIMEOUT_CYCLES, 255, bus-wait limit used only when the optional timeout feature is compiled in.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core requests an access; sampled only in IDLE
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  byte address
- core_wdata  in  32  store data, right-justified
- core_funct3  in  3  RV32I load/store width code
- core_busy  out  1  high in any state other than IDLE
- core_done  out  1  one-cycle completion pulse
- core_err  out  1  valid with core_done: access aborted
- core_rdata  out  32  extended load data; valid with core_done, then held
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts the request
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- bus_we  out  1  write request
- bus_wstrb  out  4  byte-lane strobes
- bus_wdata  out  32  lane-replicated write data
- bus_rsp_valid  in  1  response valid, for both reads and writes
- bus_rdata  in  32  read word

Behaviour:
- Reset state: FSM = IDLE. All outputs are 0, including core_rdata and bus_addr. Reset asserted mid-transaction abandons the access immediately: bus_req_valid drops asynchronously and no core_done is produced.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - If core_req=1, latch we, addr, wdata and funct3 into internal registers; the core may change its inputs afterwards.
  - Check legality. Loads: funct3 must be 000, 001, 010, 100 or 101. Stores: funct3 must be 000, 001 or 010. Halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal or misaligned: go to DONE with err=1 and no bus activity.
  - Otherwise: go to REQ.
- REQ:
  - bus_req_valid=1. bus_addr, bus_we, bus_wstrb and bus_wdata stay stable until the handshake.
  - The handshake completes in the cycle where bus_req_ready=1; the next state is RSP and bus_req_valid=0 from then on.
  - bus_rsp_valid is ignored while in REQ.
- RSP:
  - Wait for bus_rsp_valid=1.
  - On a load, capture bus_rdata steered by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Go to DONE.
- DONE: core_done=1 for exactly one cycle, then IDLE. core_req seen in DONE is not accepted.
- core_err is cleared on the next accepted request.
- Store encoding (wstrb / wdata):
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111; wdata passes through.
- Loads drive bus_wstrb = 0 and bus_we = 0.
- Latency with a zero-wait bus (ready=1 in REQ, rsp in the first RSP cycle): core_done is 3 cycles after core_req is accepted. An error access completes 1 cycle after acceptance.
- core_req while busy is ignored; there is no queuing.
- A stray bus_rsp_valid in IDLE or DONE is ignored.

Optional Feature:
- Macro: Z_CORE_MEM_TIMEOUT_EN.
- With the macro:
  - An 8+ bit counter clears on entry to REQ and increments in REQ and RSP.
  - When it reaches TIMEOUT_CYCLES, go to DONE with core_err=1 and drop bus_req_valid.
  - A late response after that point is ignored.
- Without the macro: no counter logic; the bridge waits indefinitely, and core_err flags only illegal or misaligned accesses.

Decomposition:
- Shared package z_core_mem_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state enum.
  - Default TIMEOUT_CYCLES constant.
- One natural sub-module: z_core_lane_align, a combinational block that generates wstrb and replicated wdata and does load lane extraction and extension.

Test Plan:
- LW addr 0x100, zero-wait bus, rdata 0xDEADBEEF -> bus_addr 0x100, wstrb 0; core_done 3 cycles after accept; core_rdata 0xDEADBEEF, err 0.
- LB addr 0x103, rdata 0x80FF_0000 -> core_rdata 0xFFFFFF80; LBU same access -> 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD, bus_req_ready held low 4 cycles -> bus_req_valid stays high and stable for those cycles; bus_addr 0x200, wstrb 4'b1100, wdata 0xABCDABCD.
- LW addr 0x101 -> no bus_req_valid ever; core_done and core_err = 1 one cycle after accept. SB with funct3=011 -> same error behaviour.
- reset asserted while in RSP -> bus_req_valid and core_done stay 0; FSM is IDLE. A bus_rsp_valid arriving after reset releases is ignored.
- With Z_CORE_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus never responds -> core_done and core_err after 8 wait cycles. A late rsp_valid 2 cycles after that produces no second core_done.
